// File: rtl/iob_cache_axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI4 read port (AR + R) among N cache read channels.
// One burst is outstanding at a time; R beats are routed to the granted master until rlast.
module iob_cache_axi_read_arbiter #(
    parameter int N_MASTERS  = 2,
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_LEN_W  = 8,
    parameter int AXI_ID_W   = 1,
    parameter int GRANT_W    = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [N_MASTERS-1:0]            m_arvalid_i,
    input  logic [N_MASTERS*AXI_ADDR_W-1:0] m_araddr_i,
    input  logic [N_MASTERS*AXI_LEN_W-1:0]  m_arlen_i,
    input  logic [N_MASTERS*3-1:0]          m_arsize_i,
    input  logic [N_MASTERS*2-1:0]          m_arburst_i,
    output logic [N_MASTERS-1:0]            m_arready_o,
    output logic [AXI_DATA_W-1:0]           m_rdata_o,
    output logic [1:0]                      m_rresp_o,
    output logic                            m_rlast_o,
    output logic [N_MASTERS-1:0]            m_rvalid_o,
    input  logic [N_MASTERS-1:0]            m_rready_i,
    output logic [AXI_ID_W-1:0]             axi_arid_o,
    output logic [AXI_ADDR_W-1:0]           axi_araddr_o,
    output logic [AXI_LEN_W-1:0]            axi_arlen_o,
    output logic [2:0]                      axi_arsize_o,
    output logic [1:0]                      axi_arburst_o,
    output logic                            axi_arvalid_o,
    input  logic                            axi_arready_i,
    input  logic [AXI_DATA_W-1:0]           axi_rdata_i,
    input  logic [1:0]                      axi_rresp_i,
    input  logic                            axi_rlast_i,
    input  logic                            axi_rvalid_i,
    output logic                            axi_rready_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [GRANT_W-1:0]   grant_q, grant_d;
    logic [GRANT_W-1:0]   last_grant_q, last_grant_d;
    logic [N_MASTERS-1:0] grant_onehot_s;
    logic                 granted_rready_s;

    // First requester found searching upward from last+1, wrapping modulo N_MASTERS.
    function automatic logic [GRANT_W-1:0] rr_pick(input logic [N_MASTERS-1:0] req,
                                                    input logic [GRANT_W-1:0]   last);
        logic [GRANT_W-1:0]   pick;
        logic [N_MASTERS-1:0] rot;
        logic                 found;
        int                   idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= N_MASTERS; k++) begin
            idx = (int'(last) + k) % N_MASTERS;
            rot = req >> idx;
            if (!found && rot[0]) begin
                found = 1'b1;
                pick  = GRANT_W'(idx);
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    assign grant_onehot_s   = N_MASTERS'(1) << grant_q;
    assign granted_rready_s = |(m_rready_i & grant_onehot_s);

    assign axi_arid_o    = AXI_ID_W'(grant_q);
    assign axi_araddr_o  = AXI_ADDR_W'(m_araddr_i >> (int'(grant_q) * AXI_ADDR_W));
    assign axi_arlen_o   = AXI_LEN_W'(m_arlen_i >> (int'(grant_q) * AXI_LEN_W));
    assign axi_arsize_o  = 3'(m_arsize_i >> (int'(grant_q) * 3));
    assign axi_arburst_o = 2'(m_arburst_i >> (int'(grant_q) * 2));

    assign m_rdata_o = axi_rdata_i;
    assign m_rresp_o = axi_rresp_i;
    assign m_rlast_o = axi_rlast_i;

    // State and grant registers; last_grant resets to N-1 so master 0 wins first.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GRANT_W'(N_MASTERS - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next-state, grant selection and burst-completion bookkeeping.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (|m_arvalid_i) begin
                    grant_d = rr_pick(m_arvalid_i, last_grant_q);
                    state_d = ADDR;
                end else begin
                    state_d = IDLE;
                end
            end
            ADDR: begin
                if (axi_arready_i) begin
                    state_d = DATA;
                end else begin
                    state_d = ADDR;
                end
            end
            DATA: begin
                if (axi_rvalid_i && granted_rready_s && axi_rlast_i) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end else begin
                    state_d = DATA;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake steering: only the granted master ever sees ready/valid.
    always_comb begin
        axi_arvalid_o = 1'b0;
        axi_rready_o  = 1'b0;
        m_arready_o   = '0;
        m_rvalid_o    = '0;
        case (state_q)
            ADDR: begin
                axi_arvalid_o = 1'b1;
                m_arready_o   = axi_arready_i ? grant_onehot_s : '0;
            end
            DATA: begin
                axi_rready_o = granted_rready_s;
                m_rvalid_o   = axi_rvalid_i ? grant_onehot_s : '0;
            end
            default: begin
                axi_arvalid_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_iob_cache_axi_read_arbiter.sv
// Bench for iob_cache_axi_read_arbiter: directed scenarios plus randomized bursts checked
// against a transaction-level round-robin model.
module tb_iob_cache_axi_read_arbiter;
    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 8;
    localparam int IW = 2;

    logic              clk_i, reset_i;
    logic [N-1:0]      m_arvalid_i, m_arready_o, m_rvalid_o, m_rready_i;
    logic [N*AW-1:0]   m_araddr_i;
    logic [N*LW-1:0]   m_arlen_i;
    logic [N*3-1:0]    m_arsize_i;
    logic [N*2-1:0]    m_arburst_i;
    logic [DW-1:0]     m_rdata_o, axi_rdata_i;
    logic [1:0]        m_rresp_o, axi_rresp_i, axi_arburst_o;
    logic              m_rlast_o, axi_arvalid_o, axi_arready_i, axi_rlast_i, axi_rvalid_i, axi_rready_o;
    logic [IW-1:0]     axi_arid_o;
    logic [AW-1:0]     axi_araddr_o;
    logic [LW-1:0]     axi_arlen_o;
    logic [2:0]        axi_arsize_o;

    iob_cache_axi_read_arbiter #(
        .N_MASTERS(N), .AXI_ADDR_W(AW), .AXI_DATA_W(DW), .AXI_LEN_W(LW), .AXI_ID_W(IW)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .m_arvalid_i(m_arvalid_i), .m_araddr_i(m_araddr_i), .m_arlen_i(m_arlen_i),
        .m_arsize_i(m_arsize_i), .m_arburst_i(m_arburst_i), .m_arready_o(m_arready_o),
        .m_rdata_o(m_rdata_o), .m_rresp_o(m_rresp_o), .m_rlast_o(m_rlast_o),
        .m_rvalid_o(m_rvalid_o), .m_rready_i(m_rready_i),
        .axi_arid_o(axi_arid_o), .axi_araddr_o(axi_araddr_o), .axi_arlen_o(axi_arlen_o),
        .axi_arsize_o(axi_arsize_o), .axi_arburst_o(axi_arburst_o), .axi_arvalid_o(axi_arvalid_o),
        .axi_arready_i(axi_arready_i), .axi_rdata_i(axi_rdata_i), .axi_rresp_i(axi_rresp_i),
        .axi_rlast_i(axi_rlast_i), .axi_rvalid_i(axi_rvalid_i), .axi_rready_o(axi_rready_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int vectors = 0;
    int miscompares = 0;

    // Outstanding requests as seen by the masters, and the model's last winner.
    bit          pend [N];
    logic [AW-1:0] p_addr [N];
    logic [LW-1:0] p_len [N];
    logic [2:0]    p_size [N];
    logic [1:0]    p_burst [N];
    int          mdl_last;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_ar();
        for (int i = 0; i < N; i++) begin
            m_arvalid_i[i]          = pend[i];
            m_araddr_i[i*AW +: AW]  = p_addr[i];
            m_arlen_i[i*LW +: LW]   = p_len[i];
            m_arsize_i[i*3 +: 3]    = p_size[i];
            m_arburst_i[i*2 +: 2]   = p_burst[i];
        end
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l);
        pend[i]    = 1'b1;
        p_addr[i]  = a;
        p_len[i]   = l;
        p_size[i]  = 3'($urandom_range(0, 2));
        p_burst[i] = 2'($urandom_range(0, 2));
    endtask

    function automatic int rr_expect();
        for (int k = 1; k <= N; k++) begin
            if (pend[(mdl_last + k) % N]) return (mdl_last + k) % N;
        end
        return -1;
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, "_arvalid"}, 64'(axi_arvalid_o), 64'd0);
        check({tag, "_rready"}, 64'(axi_rready_o), 64'd0);
        check({tag, "_m_arready"}, 64'(m_arready_o), 64'd0);
        check({tag, "_m_rvalid"}, 64'(m_rvalid_o), 64'd0);
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        drive_ar();
        m_rready_i = '0; axi_arready_i = 1'b0; axi_rvalid_i = 1'b0;
        axi_rlast_i = 1'b0; axi_rdata_i = '0; axi_rresp_i = 2'd0;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        clear_inputs();
        axi_rvalid_i = 1'b1;
        #1;
        check_quiet("rst");
        step();
        step();
        check_quiet("rst_hold");
        axi_rvalid_i = 1'b0;
        reset_i = 1'b0;
        mdl_last = N - 1;
    endtask

    // One arbitration + burst; abort_beats >= 0 asserts reset after that many beats.
    task automatic run_burst(input int abort_beats);
        int w, beats, acc, cyc, stall;
        logic [DW-1:0] d;
        logic [1:0] rs;
        logic rv;
        drive_ar();
        axi_arready_i = 1'b0; axi_rvalid_i = 1'b0; axi_rlast_i = 1'b0;
        #1;
        check("idle_arvalid", 64'(axi_arvalid_o), 64'd0);
        check("idle_m_arready", 64'(m_arready_o), 64'd0);
        w = rr_expect();
        step();
        check("ar_valid", 64'(axi_arvalid_o), 64'd1);
        check("ar_id", 64'(axi_arid_o), 64'(w));
        check("ar_addr", 64'(axi_araddr_o), 64'(p_addr[w]));
        check("ar_len", 64'(axi_arlen_o), 64'(p_len[w]));
        check("ar_size", 64'(axi_arsize_o), 64'(p_size[w]));
        check("ar_burst", 64'(axi_arburst_o), 64'(p_burst[w]));
        stall = $urandom_range(0, 3);
        for (int s = 0; s < stall; s++) begin
            axi_rvalid_i = 1'($urandom);
            m_rready_i   = N'($urandom);
            #1;
            check("stall_m_arready", 64'(m_arready_o), 64'd0);
            check("stall_arvalid", 64'(axi_arvalid_o), 64'd1);
            check("stall_addr", 64'(axi_araddr_o), 64'(p_addr[w]));
            check("stall_rready", 64'(axi_rready_o), 64'd0);
            check("stall_m_rvalid", 64'(m_rvalid_o), 64'd0);
            step();
        end
        axi_arready_i = 1'b1; axi_rvalid_i = 1'b0;
        #1;
        check("ar_handshake_m_arready", 64'(m_arready_o), 64'(1 << w));
        step();
        beats = int'(p_len[w]) + 1;
        pend[w] = 1'b0;
        drive_ar();
        axi_arready_i = 1'b0;
        acc = 0; cyc = 0;
        while (acc < beats && cyc < 200) begin
            rv = ($urandom_range(0, 3) != 0);
            d  = $urandom;
            rs = 2'($urandom);
            axi_rvalid_i = rv; axi_rdata_i = d; axi_rresp_i = rs;
            axi_rlast_i  = (acc == beats - 1);
            m_rready_i   = N'($urandom);
            #1;
            check("r_m_rvalid", 64'(m_rvalid_o), rv ? 64'(1 << w) : 64'd0);
            check("r_rready", 64'(axi_rready_o), 64'(m_rready_i[w]));
            check("r_data", 64'(m_rdata_o), 64'(d));
            check("r_resp", 64'(m_rresp_o), 64'(rs));
            check("r_last", 64'(m_rlast_o), 64'(acc == beats - 1));
            if (rv && m_rready_i[w]) acc++;
            step();
            cyc++;
            if (abort_beats >= 0 && acc == abort_beats) begin
                reset_i = 1'b1;
                axi_rvalid_i = 1'b1;
                m_rready_i = '1;
                #1;
                check_quiet("abort");
                clear_inputs();
                step();
                reset_i = 1'b0;
                mdl_last = N - 1;
                return;
            end
        end
        check("beat_count", 64'(acc), 64'(beats));
        axi_rvalid_i = 1'b0; axi_rlast_i = 1'b0; m_rready_i = '0;
        mdl_last = w;
        #1;
        check("post_burst_idle", 64'(axi_arvalid_o), 64'd0);
    endtask

    initial begin
        reset_i = 1'b1;
        for (int i = 0; i < N; i++) begin
            p_addr[i] = '0; p_len[i] = '0; p_size[i] = '0; p_burst[i] = '0;
        end
        clear_inputs();
        mdl_last = N - 1;
        do_reset();

        // Single master 0 burst of four beats.
        set_req(0, 32'h0000_0100, 8'd3);
        run_burst(-1);

        // Contention from reset, then continuous requests alternate 0,1,0,1.
        do_reset();
        set_req(0, 32'h0000_1000, 8'd1);
        set_req(1, 32'h0000_2000, 8'd2);
        for (int b = 0; b < 4; b++) begin
            run_burst(-1);
            if (!pend[0]) set_req(0, 32'h0000_1000 + 32'(b * 64), 8'd1);
            if (!pend[1]) set_req(1, 32'h0000_2000 + 32'(b * 64), 8'd0);
        end

        // Reset after two of four beats; master 0 wins the next contention.
        do_reset();
        set_req(0, 32'h0000_3000, 8'd3);
        run_burst(2);
        set_req(0, 32'h0000_4000, 8'd0);
        set_req(1, 32'h0000_5000, 8'd1);
        run_burst(-1);
        run_burst(-1);

        // Randomized traffic with sporadic new requesters.
        for (int b = 0; b < 40; b++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1)
                    set_req(i, $urandom & 32'hFFFF_FFFC, 8'($urandom_range(0, 4)));
            end
            if (!(pend[0] || pend[1] || pend[2]))
                set_req($urandom_range(0, N - 1), $urandom & 32'hFFFF_FFFC, 8'($urandom_range(0, 4)));
            run_burst(-1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/iob_cache_axi_read_arbiter.md
Name: iob_cache_axi_read_arbiter

Overview:
- Shares one AXI4 read port (AR + R channels) among N_MASTERS cache AXI read channels, e.g. the line-refill channels of several cache instances.
- Sits between the cache read channels and the interconnect or memory controller.
- Round-robin arbitration; exactly one burst is outstanding at a time.
- R beats are routed back to the granted master until the rlast handshake completes.

Parameters:
N_MASTERS, 2, number of requesting read channels (>=2)
AXI_ADDR_W, 32, AXI address width
AXI_DATA_W, 32, AXI data width
AXI_LEN_W, 8, AXI burst-length width
AXI_ID_W, 1, AXI ID width; must be >= GRANT_W
GRANT_W, max(1,$clog2(N_MASTERS)), derived grant index width

Ports:
clk_i  in  1  clock; all state updates on the rising edge
reset_i  in  1  asynchronous, active-high reset
m_arvalid_i  in  N_MASTERS  per-master AR valid
m_araddr_i  in  N_MASTERS*AXI_ADDR_W  per-master AR address; master i occupies bits [i*AXI_ADDR_W +: AXI_ADDR_W]
m_arlen_i  in  N_MASTERS*AXI_LEN_W  per-master burst length
m_arsize_i  in  N_MASTERS*3  per-master burst size
m_arburst_i  in  N_MASTERS*2  per-master burst type
m_arready_o  out  N_MASTERS  per-master AR ready
m_rdata_o  out  AXI_DATA_W  R data, broadcast to all masters
m_rresp_o  out  2  R response, broadcast
m_rlast_o  out  1  R last, broadcast
m_rvalid_o  out  N_MASTERS  per-master R valid; only the granted bit can be 1
m_rready_i  in  N_MASTERS  per-master R ready
axi_arid_o  out  AXI_ID_W  grant index, zero-extended
axi_araddr_o  out  AXI_ADDR_W  muxed address
axi_arlen_o  out  AXI_LEN_W  muxed burst length
axi_arsize_o  out  3  muxed burst size
axi_arburst_o  out  2  muxed burst type
axi_arvalid_o  out  1  AR valid
axi_arready_i  in  1  AR ready
axi_rdata_i  in  AXI_DATA_W  R data
axi_rresp_i  in  2  R response
axi_rlast_i  in  1  R last
axi_rvalid_i  in  1  R valid
axi_rready_o  out  1  R ready

Behaviour:
- Clocking and reset: single clock clk_i. reset_i is asynchronous and active-high.
- Registers: state (IDLE, ADDR, DATA), grant [GRANT_W], last_grant [GRANT_W].
- Reset values: state=IDLE, grant=0, last_grant=N_MASTERS-1, so master 0 has first priority.
- All outputs are combinational from the registers and inputs. While in reset or IDLE: axi_arvalid_o=0, axi_rready_o=0, m_arready_o=0, m_rvalid_o=0.
- IDLE:
  - If any m_arvalid_i bit is set, grant <= the first set index searching upward from last_grant+1, wrapping modulo N_MASTERS; state <= ADDR.
  - Otherwise stay in IDLE.
  - Arbitration latency is 1 cycle from arvalid to axi_arvalid_o.
- ADDR:
  - axi_arvalid_o=1.
  - axi_araddr/arlen/arsize/arburst_o are taken from master[grant] (combinational mux). axi_arid_o=grant.
  - m_arready_o[grant]=axi_arready_i; all other m_arready_o bits are 0.
  - On axi_arready_i=1: state <= DATA.
  - Masters must hold arvalid and fields stable until ready (AXI rule). If a master withdraws early, the arbiter still holds axi_arvalid_o=1 with the current mux output; no recovery is provided.
- DATA:
  - axi_rready_o=m_rready_i[grant]. m_rvalid_o[grant]=axi_rvalid_i; other bits are 0.
  - m_rdata/m_rresp/m_rlast_o = axi_rdata/rresp/rlast_i, broadcast unconditionally.
  - On axi_rvalid_i & m_rready_i[grant] & axi_rlast_i: last_grant <= grant; state <= IDLE.
  - Non-OKAY rresp is passed through unchanged. Error retry is the master's job.
- Boundaries:
  - A request arriving during ADDR or DATA is held off until IDLE. There is a minimum of 1 idle cycle between bursts.
  - The granted master's new arvalid in the same cycle as its own rlast is not served before the other pending masters (round-robin).
  - A single requester is re-granted every burst.
  - arlen=0 (single beat): DATA exits on the first beat.
  - axi_rvalid_i while in IDLE or ADDR is ignored (rready=0).
  - rid is not checked.
- Reset mid-burst returns immediately to IDLE with reset values. The in-flight burst is abandoned and its beats are never acknowledged; the system resets slave and masters together.

Test Plan:
- Reset: with reset_i=1, all valid/ready outputs are 0. After release, master 0 raises arvalid (araddr=0x100, arlen=3) -> axi_arvalid_o=1 exactly 1 cycle later with araddr=0x100, arid=0. Four beats reach m_rvalid_o[0] only. State returns to IDLE after the rlast handshake.
- Contention: masters 0 and 1 request in the same cycle from reset -> master 0 granted first, master 1 granted after master 0's rlast. With both continuously requesting, grants alternate 0,1,0,1.
- Backpressure: m_rready_i[grant]=0 for 3 cycles mid-burst -> axi_rready_o=0 during those cycles, no beat lost, read count equals arlen+1.
- AR stall: axi_arready_i=0 for 5 cycles -> axi_arvalid_o and the muxed fields stay constant; m_arready_o[grant] rises only with axi_arready_i.
- Slave error: rresp=2'b10 on the last beat -> m_rresp_o=2'b10 at the granted master, the burst completes normally, and the next grant follows round-robin.
- Reset mid-burst: assert reset_i after 2 of 4 beats -> state is IDLE asynchronously, outputs are 0 immediately, and the next grant goes to master 0.
